// File: rtl/gpio_debounce.sv
// gpio_debounce: per-channel synchronizer, debouncer, edge pulses and sticky change flags
module gpio_debounce #(
  parameter int NUM_CH = 8,
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter logic [NUM_CH-1:0] INIT_LEVEL = '1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pin_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] chg_flag,
  input  logic [NUM_CH-1:0] flag_clr,
  output logic              any_chg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_CH-1:0] s1, s2, stable, done, chg_nxt;
  logic [CW-1:0] cnt [NUM_CH];
  // a channel accepts its new level when the mismatch has held for the full count
  always_comb
    for (int i = 0; i < NUM_CH; i++)
      done[i] = (s2[i] != stable[i]) && (cnt[i] == CMAX);
  assign chg_nxt = done | (chg_flag & ~flag_clr);
  assign level_out = stable;
  // per-channel counter restarts whenever the synchronized pin agrees with the stable level
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    always_ff @(posedge sys_clk)
      cnt[g] <= (reset || s2[g] == stable[g] || done[g]) ? '0 : cnt[g] + 1'b1;
  end
  // synchronizer, stable level, edge pulses, sticky flags (set beats clear) and summary
  always_ff @(posedge sys_clk)
    if (reset) begin
      s1 <= INIT_LEVEL;
      s2 <= INIT_LEVEL;
      stable <= INIT_LEVEL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      chg_flag <= '0;
      any_chg <= 1'b0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
      stable <= (stable & ~done) | (s2 & done);
      rise_pulse <= done & s2;
      fall_pulse <= done & ~s2;
      chg_flag <= chg_nxt;
      any_chg <= |chg_nxt;
    end
endmodule
